dac_spi_tx: RTL and testbench
=============================

// Module: dac_spi_tx
// PURPOSE
//  Downstream of the saturating summer. Takes each 12-bit unsigned offset-binary sample and serialises it to the LTC2624 quad DAC over SPI.
//  Each sample is sent as one 32-bit write-and-update frame, MSB first.
//  Sits between the summer output and the board pins dac_cs_n/dac_sck/dac_mosi/dac_clr_n.
// PARAMETERS
//  CLK_DIV   2        clk cycles per SCK half-period (>=1)
//  DAC_CMD   4'b0011  LTC2624 command nibble (write to and update n)
//  DAC_ADDR  4'b0000  LTC2624 address nibble (DAC A; 4'b1111 = all)
// PORTS
//  clk           in   1   system clock; single clock domain
//  rst_n         in   1   asynchronous, active-low reset
//  sample_in     in   12  sample from summer, unsigned offset binary
//  sample_valid  in   1   sample_in valid this cycle
//  ready         out  1   block can accept a sample this cycle
//  frame_done    out  1   one-cycle pulse when the frame finishes
//  overrun       out  1   sticky: sample_valid seen while ready=0
//  dac_cs_n      out  1   SPI chip select, active low
//  dac_sck       out  1   SPI clock, idle low
//  dac_mosi      out  1   SPI data; DAC samples it on rising SCK
//  dac_clr_n     out  1   DAC async clear, active low
// BEHAVIOUR
//  Reset values (while rst_n=0):
//   dac_cs_n=1, dac_sck=0, dac_mosi=0, dac_clr_n=0, frame_done=0, overrun=0.
//   ready=1, because ready = (state==IDLE).
//  dac_clr_n is registered; it goes to 1 on the first clk edge after rst_n rises.
//  Frame word (32 bits): {8'h00, DAC_CMD, DAC_ADDR, sample_in[11:0], 4'h0}, sent bit31 first.
//   Captured into the shift register on accept. sample_in may change after that.
//  States: IDLE -> SHIFT -> GAP -> IDLE.
//  Accept: sample_valid & ready at a clk edge. The next cycle is SHIFT:
//   dac_cs_n=0, dac_sck=0, dac_mosi=bit31.
//  Half-period counter runs 0..CLK_DIV-1. On each wrap dac_sck toggles.
//   Rising toggle: the bit counter increments.
//   Falling toggle: shift left; dac_mosi = next bit.
//  dac_mosi is stable for CLK_DIV cycles on both sides of every rising edge.
//  After the 32nd rising edge, the following falling-toggle point ends the frame:
//   dac_sck=0, dac_cs_n=1, dac_mosi=0, frame_done=1 for one cycle.
//   State goes to GAP.
//  GAP: dac_cs_n held high for CLK_DIV cycles, then IDLE (ready=1).
//  Frame length, accept edge to frame_done: 64*CLK_DIV+1 cycles (129 at default).
//   Next accept is possible CLK_DIV cycles later.
//  Exactly 32 rising SCK edges occur while dac_cs_n=0. No SCK edge occurs while dac_cs_n=1.
//  sample_valid while ready=0: sample dropped, overrun set to 1. overrun clears only on reset.
//  Accept and frame_done never coincide, since ready=0 until GAP completes.
//  Reset mid-frame: all outputs go to reset values immediately, asynchronously. The frame is abandoned; no partial update is latched (CS rises before any 32nd edge).
//  Data is forwarded unmodified. Saturated input 12'hFFF is sent as 12'hFFF; no wrap.
// TESTING
//  Reset: rst_n=0 mid-SHIFT -> cs_n=1, sck=0, mosi=0, clr_n=0 same cycle; clr_n=1 one edge after release.
//  Single frame: sample_in=12'hA5C, CLK_DIV=2 -> 32 bits 0x0030A5C0 sampled on rising SCK; frame_done 129 cycles after accept.
//  Extremes: 12'h000 then 12'hFFF -> 0x00300000 and 0x0030FFF0; exactly 32 SCK rises per CS-low window.
//  Back-to-back: valid held high with 3 samples -> 3 frames; CS high for exactly CLK_DIV cycles between them; overrun=1.
//  Overrun: pulse valid at cycle 10 of a frame -> sample dropped, next frame still carries the earlier data, overrun stays 1.
//  Param sweep: CLK_DIV=1 and 5, DAC_ADDR=4'hF -> SCK half-period matches; frame word is 0x003F_xxx0.

Source files
------------

// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_tx
// Brief    : Serialises 12-bit offset-binary samples into 32-bit LTC2624
//            write-and-update SPI frames (MSB first, SCK idle low).
// Revision : 1.0 - initial release
// ============================================================================

module dac_spi_tx #(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [3:0]  DAC_CMD  = 4'b0011,
  parameter logic [3:0]  DAC_ADDR = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic        ready,
  output logic        frame_done,
  output logic        overrun,
  output logic        dac_cs_n,
  output logic        dac_sck,
  output logic        dac_mosi,
  output logic        dac_clr_n
);

  localparam int unsigned        c_CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_HALF_MAX = c_CNT_W'(CLK_DIV - 1);
  localparam logic [5:0]         c_LAST_BIT = 6'd32;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_GAP   = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [31:0]        r_shift;
  logic [c_CNT_W-1:0] r_half_cnt;
  logic [5:0]         r_bit_cnt;
  logic               r_sck;
  logic               r_frame_done;
  logic               r_overrun;
  logic               r_clr_n;

  logic               w_accept;
  logic               w_wrap;
  logic               w_rise;
  logic               w_fall;
  logic               w_frame_end;

  assign w_accept    = sample_valid && (r_state == c_IDLE);
  assign w_wrap      = (r_half_cnt == c_HALF_MAX);
  assign w_rise      = (r_state == c_SHIFT) && w_wrap && !r_sck;
  assign w_fall      = (r_state == c_SHIFT) && w_wrap && r_sck;
  // The falling-toggle point after the 32nd rise closes the frame instead of shifting.
  assign w_frame_end = w_fall && (r_bit_cnt == c_LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept)    w_state_nxt = c_SHIFT;
      c_SHIFT: if (w_frame_end) w_state_nxt = c_GAP;
      c_GAP:   if (w_wrap)      w_state_nxt = c_IDLE;
      default:                  w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_half_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_sck        <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_clr_n      <= 1'b0;
    end else begin
      r_clr_n      <= 1'b1;
      r_frame_done <= w_frame_end;
      if (sample_valid && (r_state != c_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_shift    <= {8'h00, DAC_CMD, DAC_ADDR, sample_in, 4'h0};
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_sck      <= 1'b0;
          end
        end
        c_SHIFT: begin
          r_half_cnt <= w_wrap ? '0 : r_half_cnt + 1'b1;
          if (w_rise) begin
            r_sck     <= 1'b1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end else if (w_fall) begin
            r_sck <= 1'b0;
            if (!w_frame_end) begin
              r_shift <= {r_shift[30:0], 1'b0};
            end
          end
        end
        c_GAP: begin
          r_half_cnt <= w_wrap ? '0 : r_half_cnt + 1'b1;
        end
        default: begin
          r_half_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ready    = 1'b0;
    dac_cs_n = 1'b1;
    dac_sck  = 1'b0;
    dac_mosi = 1'b0;
    case (r_state)
      c_IDLE: begin
        ready = 1'b1;
      end
      c_SHIFT: begin
        dac_cs_n = 1'b0;
        dac_sck  = r_sck;
        dac_mosi = r_shift[31];
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;
  assign dac_clr_n  = r_clr_n;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dac_spi_tx
// Brief    : Scoreboard bench for dac_spi_tx; three instances cover CLK_DIV 2/1/5.
// Revision : 1.0 - initial release
// ============================================================================

module tb_dac_spi_tx;

  localparam int c_N = 3;

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b0;
  logic [11:0] sample_in    = '0;
  logic        sample_valid = 1'b0;
  int          sel          = 0;
  int          cyc          = 0;
  bit          b2b_en       = 1'b0;

  logic [c_N-1:0] valid_v, ready_v, done_v, ovr_v, cs_v, sck_v, mosi_v, clr_v;
  logic m_valid, m_ready, m_done, m_ovr, m_cs, m_sck, m_mosi, m_clr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < c_N; i++) begin : g_dut
    assign valid_v[i] = sample_valid && (sel == i);
    dac_spi_tx #(
      .CLK_DIV  ((i == 0) ? 2 : ((i == 1) ? 1 : 5)),
      .DAC_CMD  (4'b0011),
      .DAC_ADDR ((i == 2) ? 4'hF : 4'h0)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_in    (sample_in),
      .sample_valid (valid_v[i]),
      .ready        (ready_v[i]),
      .frame_done   (done_v[i]),
      .overrun      (ovr_v[i]),
      .dac_cs_n     (cs_v[i]),
      .dac_sck      (sck_v[i]),
      .dac_mosi     (mosi_v[i]),
      .dac_clr_n    (clr_v[i])
    );
  end

  assign m_valid = valid_v[sel];
  assign m_ready = ready_v[sel];
  assign m_done  = done_v[sel];
  assign m_ovr   = ovr_v[sel];
  assign m_cs    = cs_v[sel];
  assign m_sck   = sck_v[sel];
  assign m_mosi  = mosi_v[sel];
  assign m_clr   = clr_v[sel];

  function automatic int div_of(input int s);
    return (s == 0) ? 2 : ((s == 1) ? 1 : 5);
  endfunction

  function automatic logic [31:0] exp_word(input int s, input logic [11:0] d);
    logic [3:0] a;
    a = (s == 2) ? 4'hF : 4'h0;
    return {8'h00, 4'h3, a, d, 4'h0};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard + SPI decoder, sampled on the falling clk edge.
  logic [31:0] sb_q[$];
  int          acc_q[$];
  logic        prev_cs   = 1'b1;
  logic        prev_sck  = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] bits      = '0;
  int          rises     = 0;
  int          hi_len    = 0;
  int          lo_len    = 0;
  int          last_done = 0;
  bit          have_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      acc_q.delete();
      prev_cs   = 1'b1;
      prev_sck  = 1'b0;
      prev_done = 1'b0;
      have_done = 1'b0;
    end else begin
      if (!b2b_en) have_done = 1'b0;
      if (m_valid && m_ready) begin
        sb_q.push_back(exp_word(sel, sample_in));
        if (b2b_en && have_done) check("gap_done_to_accept", cyc - last_done, div_of(sel));
        acc_q.push_back(cyc);
      end
      if (!prev_cs || !m_cs) begin
        if (prev_cs && !m_cs) begin
          bits   = '0;
          rises  = 0;
          lo_len = 1;
          hi_len = 0;
        end else if (m_sck && !prev_sck) begin
          check("sck_low_len", lo_len, div_of(sel));
          hi_len = 1;
          rises++;
          bits = {bits[30:0], m_mosi};
        end else if (!m_sck && prev_sck) begin
          check("sck_high_len", hi_len, div_of(sel));
          lo_len = 1;
        end else if (m_sck) begin
          hi_len++;
        end else begin
          lo_len++;
        end
        if (!prev_cs && m_cs) begin
          check("sck_rises", rises, 32);
          check("sck_idle_end", m_sck, 1'b0);
          check("mosi_idle_end", m_mosi, 1'b0);
          check("done_at_cs_rise", m_done, 1'b1);
          if (sb_q.size() == 0) check("sb_underflow", 0, 1);
          else check("frame_word", bits, sb_q.pop_front());
        end
      end else if (m_sck != prev_sck) begin
        check("sck_edge_cs_high", m_sck, prev_sck);
      end
      if (prev_done && m_done) check("done_one_cycle", m_done, 1'b0);
      if (m_done) begin
        if (acc_q.size() == 0) check("done_without_accept", 0, 1);
        else check("done_latency", cyc - acc_q.pop_front(), 64 * div_of(sel) + 1);
        last_done = cyc;
        have_done = b2b_en;
      end
      prev_cs   = m_cs;
      prev_sck  = m_sck;
      prev_done = m_done;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!m_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [11:0] d);
    wait_ready();
    sample_in    = d;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(m_ready && sb_q.size() == 0 && acc_q.size() == 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) check("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cs_n"},       m_cs,   1'b1);
    check({pfx, "_sck"},        m_sck,  1'b0);
    check({pfx, "_mosi"},       m_mosi, 1'b0);
    check({pfx, "_clr_n"},      m_clr,  1'b0);
    check({pfx, "_frame_done"}, m_done, 1'b0);
    check({pfx, "_overrun"},    m_ovr,  1'b0);
    check({pfx, "_ready"},      m_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] b2b_data [3];
    b2b_data[0] = 12'h111;
    b2b_data[1] = 12'h222;
    b2b_data[2] = 12'h333;

    // Power-on reset and clr_n release
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1 check("clr_n_before_edge", m_clr, 1'b0);
    @(posedge clk); #1;
    check("clr_n_after_edge", m_clr, 1'b1);

    // Single frame and extremes
    send(12'hA5C);
    wait_idle();
    send(12'h000);
    wait_idle();
    send(12'hFFF);
    wait_idle();
    check("overrun_quiet", m_ovr, 1'b0);

    // Back-to-back with valid held high
    b2b_en       = 1'b1;
    sample_in    = b2b_data[0];
    sample_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ready();
      sample_in = b2b_data[k];
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    wait_idle();
    b2b_en = 1'b0;
    check("overrun_b2b", m_ovr, 1'b1);

    // Mid-frame asynchronous reset
    send(12'hA5C);
    begin
      int n = 0;
      while (!m_sck && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("sck_high_before_reset", m_sck, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check("midrst_clr_n_before_edge", m_clr, 1'b0);
    @(posedge clk); #1;
    check("midrst_clr_n_after_edge", m_clr, 1'b1);

    // Overrun pulse at cycle 10 of a frame
    send(12'h3C3);
    repeat (9) @(posedge clk);
    #1;
    sample_in    = 12'h777;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    sample_in    = 12'h000;
    check("overrun_set", m_ovr, 1'b1);
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    check("overrun_sticky", m_ovr, 1'b1);

    // Parameter sweep: CLK_DIV=1, then CLK_DIV=5 with DAC_ADDR=F
    sel = 1;
    send(12'h123);
    wait_idle();
    sel = 2;
    send(12'h9B7);
    wait_idle();
    send(12'hFFF);
    wait_idle();

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
